keystream_xor_cipher: RTL
=========================

Name: keystream_xor_cipher

Overview:
- Consumer end of the Lorenz keystream AXI-Stream link. Accepts 8-bit key bytes on a slave port and buffers them in a small FIFO.
- XORs each key byte with one plaintext byte arriving on a second AXI-Stream slave, and emits the result on an AXI-Stream master with frame delimiting (tlast).
- The same block serves as encryptor and decryptor, since XOR is symmetric.
- Frame, byte and key-underrun status counters are provided for debug.

Parameters:
KEY_DEPTH, 8, key FIFO depth; power of 2, >= 2
CNT_W, 16, width of status counters

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
key_tdata  in  8  keystream byte from the Lorenz generator
key_tvalid  in  1  key byte valid
key_tready  out  1  key FIFO can accept
s_tdata  in  8  plaintext/ciphertext input byte
s_tvalid  in  1  input byte valid
s_tlast  in  1  last byte of frame
s_tready  out  1  input byte accepted this cycle when s_tvalid=1
m_tdata  out  8  s_tdata XOR key byte
m_tvalid  out  1  output valid
m_tlast  out  1  copy of accepted s_tlast
m_tready  in  1  downstream ready
key_level  out  clog2(KEY_DEPTH)+1  current key FIFO occupancy
frame_count  out  CNT_W  completed frames, wraps
byte_count  out  CNT_W  bytes output since reset, wraps
stall_count  out  CNT_W  key-underrun stall cycles, saturating

Behaviour:
- Reset state (async, immediate):
  - FIFO empty, key_level=0, state=IDLE.
  - m_tvalid=0, m_tdata=0, m_tlast=0.
  - All counters 0.
  - key_tready=0 and s_tready=0 while rst is high.
- Key FIFO:
  - key_tready = !rst && (key_level != KEY_DEPTH), combinational.
  - Push when key_tvalid && key_tready. Order is preserved.
  - Pop only on a data fire.
  - No bypass: a key pushed in cycle N is first usable in cycle N+1.
  - At full: push is blocked; a pop in the same cycle still occurs, so level decrements.
  - At empty: pop is impossible.
  - Simultaneous push and pop leaves the level unchanged.
  - Read and write pointers wrap modulo KEY_DEPTH.
- Data path:
  - out_free = !m_tvalid || m_tready.
  - s_tready = !rst && (key_level != 0) && out_free.
  - fire = s_tvalid && s_tready.
  - On fire: m_tdata <= s_tdata ^ fifo_head, m_tlast <= s_tlast, m_tvalid <= 1, pop the FIFO. Latency is 1 cycle.
  - If m_tvalid && m_tready and there is no fire: m_tvalid <= 0.
  - While m_tvalid=1 and m_tready=0: m_tdata and m_tlast are held stable, and there is no pop.
  - Full throughput is one byte per cycle when keys are available.
- Frame FSM:
  - IDLE:
    - fire && !s_tlast -> ACTIVE.
    - fire && s_tlast -> stay IDLE (single-byte frame), frame_count++.
  - ACTIVE:
    - fire && s_tlast -> IDLE, frame_count++.
  - Otherwise hold state.
  - The FSM does not gate s_tready; it tracks framing for status only.
- Counters:
  - byte_count increments on every fire, and wraps.
  - stall_count increments each cycle that s_tvalid && out_free && key_level==0, and saturates at all-ones.
- Reset mid-frame: the in-flight output byte and buffered keys are discarded, the FSM returns to IDLE, and the partial frame is not counted.

Test Plan:
- Reset -> m_tvalid=0, m_tdata=0x00, key_level=0, all counters 0, key_tready=0 during rst and 1 the cycle after release.
- Push keys 0x11, 0x22, 0x33; send 0xA0, 0xB0, 0xC0 (tlast on 0xC0) with m_tready=1 -> m_tdata 0xB1, 0x92, 0xF3, each 1 cycle after its accept, m_tlast only on 0xF3; then frame_count=1, byte_count=3, key_level=0, state IDLE.
- Offer 9 keys back-to-back with no data -> 8 accepted, key_tready=0 on the 9th, key_level=8. Then one data fire while key_tvalid=1 -> level 7, key_tready=1 next cycle.
- FIFO empty, s_tvalid=1 for 5 cycles -> s_tready=0, stall_count=5. Then push key 0x5A with s_tdata=0x00 -> fire 1 cycle after the key accept, m_tdata=0x5A.
- Hold m_tready=0 with m_tvalid=1 and s_tvalid=1 -> m_tdata stable, s_tready=0, key_level unchanged. Release m_tready -> transfers resume at 1 byte/cycle.
- Assert rst after 2 bytes of a 4-byte frame -> m_tvalid=0 immediately, key_level=0, frame_count unchanged, state IDLE. The next full frame counts as frame 1.

Source files
------------

// File: rtl/keystream_xor_cipher_if.sv
// Stream bundle for keystream_xor_cipher: key input, data input and data output.
//   key_* : key bytes from the keystream generator (tdata/tvalid in, tready out)
//   s_*   : plaintext or ciphertext bytes with frame delimiter (tready out)
//   m_*   : XOR result with frame delimiter (tready in)
// slave modport is the cipher's view; master modport is the surrounding system's view.
interface keystream_xor_cipher_if;
    logic [7:0] key_tdata;
    logic       key_tvalid;
    logic       key_tready;

    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;

    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready;

    modport slave (
        input  key_tdata, key_tvalid,
        output key_tready,
        input  s_tdata, s_tvalid, s_tlast,
        output s_tready,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready
    );

    modport master (
        output key_tdata, key_tvalid,
        input  key_tready,
        output s_tdata, s_tvalid, s_tlast,
        input  s_tready,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready
    );
endinterface

// File: rtl/keystream_xor_cipher.sv
// Keystream XOR cipher: buffers key bytes in a FIFO and XORs one key byte onto
// each data byte, emitting the result with tlast. Works as encryptor or decryptor.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : key / data-in / data-out streams (slave modport)
//   key_level    : key FIFO occupancy
//   frame_count  : completed frames (wraps)
//   byte_count   : bytes accepted since reset (wraps)
//   stall_count  : cycles data waited on an empty key FIFO (saturates)
module keystream_xor_cipher #(
    parameter int unsigned KEY_DEPTH = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    keystream_xor_cipher_if.slave       bus,
    output logic [$clog2(KEY_DEPTH):0]  key_level,
    output logic [CNT_W-1:0]            frame_count,
    output logic [CNT_W-1:0]            byte_count,
    output logic [CNT_W-1:0]            stall_count
);

    localparam int unsigned PTR_W = $clog2(KEY_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Key FIFO storage and pointers
    logic [7:0]       r_mem [KEY_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Output register stage
    logic [7:0]       r_m_tdata;
    logic             r_m_tvalid;
    logic             r_m_tlast;

    // Status
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_key_empty;
    logic             w_key_full;
    logic             w_push;
    logic             w_out_free;
    logic             w_s_tready;
    logic             w_fire;
    logic             w_stall;
    logic             w_frame_done;
    logic [7:0]       w_key_head;

    assign w_key_empty = (r_level == '0);
    assign w_key_full  = (r_level == LVL_W'(KEY_DEPTH));

    assign bus.key_tready = !rst && !w_key_full;
    assign w_push         = bus.key_tvalid && !rst && !w_key_full;

    // Output register can take a new byte when empty or being drained this cycle
    assign w_out_free  = !r_m_tvalid || bus.m_tready;
    assign w_s_tready  = !rst && !w_key_empty && w_out_free;
    assign bus.s_tready = w_s_tready;
    assign w_fire      = bus.s_tvalid && w_s_tready;
    assign w_stall     = bus.s_tvalid && w_out_free && w_key_empty;
    assign w_key_head  = r_mem[r_rd_ptr];

    // Key storage has no reset: contents are only read behind a nonzero level
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.key_tdata;
        end
    end

    // FIFO pointers and occupancy; pop happens only on a data fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_fire})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Output stage: load on fire, clear when drained without a replacement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_fire) begin
            r_m_tdata  <= bus.s_tdata ^ w_key_head;
            r_m_tlast  <= bus.s_tlast;
            r_m_tvalid <= 1'b1;
        end else if (bus.m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // Frame FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fire && !bus.s_tlast) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_fire && bus.s_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame FSM: outputs (a frame closes on any accepted tlast byte, single-byte frames included)
    always_comb begin
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE:   w_frame_done = w_fire && bus.s_tlast;
            ST_ACTIVE: w_frame_done = w_fire && bus.s_tlast;
            default:   w_frame_done = 1'b0;
        endcase
    end

    // Status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_fire) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.m_tdata  = r_m_tdata;
    assign bus.m_tvalid = r_m_tvalid;
    assign bus.m_tlast  = r_m_tlast;
    assign key_level    = r_level;
    assign frame_count  = r_frame_cnt;
    assign byte_count   = r_byte_cnt;
    assign stall_count  = r_stall_cnt;

endmodule
